// File: rtl/ifu_fetch_unit.sv
// Instruction-fetch stage: one outstanding read on the instruction bus, valid/ready hand-off to ID,
// and discard of in-flight fetches when ID redirects control flow.
module ifu_fetch_unit #(
    parameter int unsigned ADDR_W = 64,
    parameter int unsigned DATA_W = 64
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] pc_in,
    output logic              pc_ready,
    input  logic              redirect,
    output logic              arvalid,
    output logic [ADDR_W-1:0] araddr,
    input  logic              arready,
    input  logic              rvalid,
    input  logic [DATA_W-1:0] rdata,
    input  logic [1:0]        rresp,
    output logic              rready,
    output logic              inst_valid,
    output logic [31:0]       inst,
    output logic [ADDR_W-1:0] inst_pc,
    output logic              inst_fault,
    input  logic              id_ready
);

    typedef enum logic [2:0] {
        StIdle,
        StAr,
        StR,
        StHold,
        StDrop
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] req_pc_q, req_pc_d;
    logic              kill_q, kill_d;
    logic [31:0]       inst_q, inst_d;
    logic [ADDR_W-1:0] inst_pc_q, inst_pc_d;
    logic              inst_fault_q, inst_fault_d;
    logic [31:0]       lane_word;

    // pc[2] picks the 32-bit half of a 64-bit beat; narrower buses carry one word per beat.
    generate
        if (DATA_W >= 64) begin : g_lane_sel
            assign lane_word = req_pc_q[2] ? rdata[63:32] : rdata[31:0];
        end else begin : g_lane_fixed
            assign lane_word = rdata[31:0];
        end
    endgenerate

    always_comb begin
        state_d      = state_q;
        req_pc_d     = req_pc_q;
        kill_d       = kill_q;
        inst_d       = inst_q;
        inst_pc_d    = inst_pc_q;
        inst_fault_d = inst_fault_q;
        arvalid      = 1'b0;
        rready       = 1'b0;
        inst_valid   = 1'b0;
        pc_ready     = 1'b0;

        unique case (state_q)
            StIdle: begin
                req_pc_d = pc_in;
                kill_d   = 1'b0;
                state_d  = StAr;
            end
            StAr: begin
                arvalid = 1'b1;
                if (arready) begin
                    state_d = (kill_q || redirect) ? StDrop : StR;
                end else if (redirect) begin
                    // Address already offered cannot be withdrawn; remember to drop its data.
                    kill_d = 1'b1;
                end
            end
            StR: begin
                rready = 1'b1;
                if (rvalid) begin
                    if (redirect) begin
                        state_d = StIdle;
                    end else begin
                        inst_d       = lane_word;
                        inst_pc_d    = req_pc_q;
                        inst_fault_d = (rresp != 2'b00);
                        state_d      = StHold;
                    end
                end else if (redirect) begin
                    state_d = StDrop;
                end
            end
            StHold: begin
                inst_valid = 1'b1;
                if (redirect) begin
                    state_d = StIdle;
                end else if (id_ready) begin
                    pc_ready = 1'b1;
                    state_d  = StIdle;
                end
            end
            StDrop: begin
                rready = 1'b1;
                if (rvalid) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= StIdle;
            req_pc_q     <= '0;
            kill_q       <= 1'b0;
            inst_q       <= '0;
            inst_pc_q    <= '0;
            inst_fault_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            req_pc_q     <= req_pc_d;
            kill_q       <= kill_d;
            inst_q       <= inst_d;
            inst_pc_q    <= inst_pc_d;
            inst_fault_q <= inst_fault_d;
        end
    end

    assign araddr     = {req_pc_q[ADDR_W-1:3], 3'b000};
    assign inst       = inst_q;
    assign inst_pc    = inst_pc_q;
    assign inst_fault = inst_fault_q;

endmodule

// File: tb/tb_ifu_fetch_unit.sv
// Bench for ifu_fetch_unit: a transaction-level model of the in-flight fetch, directed scenarios
// with literal expectations, then randomized bus/ID traffic checked every cycle.
module tb_ifu_fetch_unit;

    localparam int unsigned ADDR_W = 64;
    localparam int unsigned DATA_W = 64;
    localparam logic [63:0] BEAT   = 64'h00100093_00000413;

    logic              clock = 1'b0;
    logic              reset = 1'b0;
    logic [ADDR_W-1:0] pc_in = '0;
    logic              pc_ready;
    logic              redirect = 1'b0;
    logic              arvalid;
    logic [ADDR_W-1:0] araddr;
    logic              arready = 1'b0;
    logic              rvalid = 1'b0;
    logic [DATA_W-1:0] rdata = '0;
    logic [1:0]        rresp = 2'b00;
    logic              rready;
    logic              inst_valid;
    logic [31:0]       inst;
    logic [ADDR_W-1:0] inst_pc;
    logic              inst_fault;
    logic              id_ready = 1'b0;

    ifu_fetch_unit #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clock      (clock),
        .reset      (reset),
        .pc_in      (pc_in),
        .pc_ready   (pc_ready),
        .redirect   (redirect),
        .arvalid    (arvalid),
        .araddr     (araddr),
        .arready    (arready),
        .rvalid     (rvalid),
        .rdata      (rdata),
        .rresp      (rresp),
        .rready     (rready),
        .inst_valid (inst_valid),
        .inst       (inst),
        .inst_pc    (inst_pc),
        .inst_fault (inst_fault),
        .id_ready   (id_ready)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;
    int pcr_cnt = 0;
    int iv_cnt  = 0;

    // The single in-flight fetch, described by its progress flags.
    bit          m_active;
    logic [63:0] m_pc;
    bit          m_doomed;
    bit          m_addr_done;
    bit          m_data_done;
    logic [31:0] m_inst;
    logic [63:0] m_inst_pc;
    bit          m_fault;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_active = 0; m_doomed = 0; m_addr_done = 0; m_data_done = 0;
    endtask

    // One clock cycle: drive inputs after the falling edge, compare, then advance the model.
    task automatic step(input logic [63:0] pcin, input bit arr, input bit rv,
                        input logic [63:0] rd, input logic [1:0] rr, input bit redir,
                        input bit idr);
        bit e_arvalid, e_rready, e_iv, e_pcr, rv_eff;
        @(negedge clock);
        e_arvalid = m_active && !m_addr_done;
        e_rready  = m_active && m_addr_done && !m_data_done;
        e_iv      = m_active && m_data_done;
        e_pcr     = e_iv && idr && !redir;
        rv_eff    = rv && e_rready;
        pc_in = pcin; arready = arr; rvalid = rv_eff; rdata = rd; rresp = rr;
        redirect = redir; id_ready = idr;
        #1;
        chk("arvalid", {63'd0, arvalid}, {63'd0, e_arvalid});
        chk("rready", {63'd0, rready}, {63'd0, e_rready});
        chk("inst_valid", {63'd0, inst_valid}, {63'd0, e_iv});
        chk("pc_ready", {63'd0, pc_ready}, {63'd0, e_pcr});
        if (e_arvalid) chk("araddr", araddr, {m_pc[63:3], 3'b000});
        if (e_iv) begin
            chk("inst", {32'd0, inst}, {32'd0, m_inst});
            chk("inst_pc", inst_pc, m_inst_pc);
            chk("inst_fault", {63'd0, inst_fault}, {63'd0, m_fault});
        end
        if (pc_ready === 1'b1) pcr_cnt++;
        if (inst_valid === 1'b1) iv_cnt++;

        if (!m_active) begin
            m_active = 1; m_pc = pcin; m_doomed = 0; m_addr_done = 0; m_data_done = 0;
        end else if (!m_addr_done) begin
            if (redir) m_doomed = 1;
            if (arr) m_addr_done = 1;
        end else if (!m_data_done) begin
            if (rv_eff) begin
                if (m_doomed || redir) begin
                    m_active = 0;
                end else begin
                    m_data_done = 1;
                    m_inst      = m_pc[2] ? rd[63:32] : rd[31:0];
                    m_inst_pc   = m_pc;
                    m_fault     = (rr != 2'b00);
                end
            end else if (redir) begin
                m_doomed = 1;
            end
        end else if (redir || idr) begin
            m_active = 0;
        end
    endtask

    initial begin
        int pc0, iv0;
        logic [63:0] rpc, rd;
        logic [1:0]  rr;
        model_reset();
        #1;
        chk("rst_arvalid", {63'd0, arvalid}, 64'd0);
        chk("rst_rready", {63'd0, rready}, 64'd0);
        chk("rst_inst_valid", {63'd0, inst_valid}, 64'd0);
        chk("rst_pc_ready", {63'd0, pc_ready}, 64'd0);
        chk("rst_inst_fault", {63'd0, inst_fault}, 64'd0);
        chk("rst_inst", {32'd0, inst}, 64'd0);
        chk("rst_inst_pc", inst_pc, 64'd0);
        chk("rst_araddr", araddr, 64'd0);
        repeat (2) @(posedge clock);
        #2 reset = 1'b1;

        // Basic fetch, lower lane.
        pc0 = pcr_cnt;
        step(64'h8000_0000, 0, 0, 0, 0, 0, 1);
        step(64'h8000_0000, 1, 0, 0, 0, 0, 1);
        chk("basic_araddr", araddr, 64'h8000_0000);
        step(64'h8000_0000, 0, 1, BEAT, 0, 0, 1);
        step(64'h8000_0000, 0, 0, 0, 0, 0, 1);
        chk("basic_inst", {32'd0, inst}, 64'h0000_0413);
        chk("basic_inst_pc", inst_pc, 64'h8000_0000);
        chk("basic_pc_ready", {63'd0, pc_ready}, 64'd1);
        chk("basic_pcr_once", 64'(pcr_cnt - pc0), 64'd1);

        // Upper lane with three cycles of ID backpressure.
        pc0 = pcr_cnt; iv0 = iv_cnt;
        step(64'h8000_0004, 0, 0, 0, 0, 0, 0);
        step(64'h8000_0004, 1, 0, 0, 0, 0, 0);
        step(64'h8000_0004, 0, 1, BEAT, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            step(64'h8000_0004, 0, 0, 0, 0, 0, (i == 3));
            chk("bp_inst", {32'd0, inst}, 64'h0010_0093);
            chk("bp_pc_ready", {63'd0, pc_ready}, (i == 3) ? 64'd1 : 64'd0);
        end
        chk("bp_valid_cycles", 64'(iv_cnt - iv0), 64'd4);
        chk("bp_pcr_once", 64'(pcr_cnt - pc0), 64'd1);

        // Address stall with redirect: data must be dropped.
        iv0 = iv_cnt;
        step(64'h8000_0008, 0, 0, 0, 0, 0, 1);
        step(64'h8000_0100, 0, 0, 0, 0, 1, 1);
        chk("stall_araddr0", araddr, 64'h8000_0008);
        step(64'h8000_0100, 0, 0, 0, 0, 0, 1);
        chk("stall_araddr1", araddr, 64'h8000_0008);
        step(64'h8000_0100, 1, 0, 0, 0, 0, 1);
        step(64'h8000_0100, 0, 1, BEAT, 0, 0, 1);
        chk("drop_rready", {63'd0, rready}, 64'd1);
        step(64'h8000_0100, 0, 0, 0, 0, 0, 1);
        chk("drop_no_inst", 64'(iv_cnt - iv0), 64'd0);
        step(64'h8000_0100, 1, 0, 0, 0, 0, 1);
        chk("redir_target", araddr, 64'h8000_0100);
        step(64'h8000_0100, 0, 1, BEAT, 0, 0, 1);
        step(64'h8000_0100, 0, 0, 0, 0, 0, 1);

        // Redirect together with rvalid, then redirect in HOLD beating id_ready.
        step(64'h8000_0010, 0, 0, 0, 0, 0, 1);
        step(64'h8000_0010, 1, 0, 0, 0, 0, 1);
        step(64'h8000_0010, 0, 1, BEAT, 0, 1, 1);
        step(64'h8000_0018, 0, 0, 0, 0, 0, 1);
        chk("rredir_no_valid", {63'd0, inst_valid}, 64'd0);
        step(64'h8000_0018, 1, 0, 0, 0, 0, 1);
        step(64'h8000_0018, 0, 1, BEAT, 0, 0, 1);
        step(64'h8000_0018, 0, 0, 0, 0, 1, 1);
        chk("hredir_pc_ready", {63'd0, pc_ready}, 64'd0);
        step(64'h8000_0020, 0, 0, 0, 0, 0, 1);
        chk("hredir_valid_low", {63'd0, inst_valid}, 64'd0);

        // Bus error still delivers, next fetch is clean.
        step(64'h8000_0020, 1, 0, 0, 0, 0, 1);
        step(64'h8000_0020, 0, 1, BEAT, 2'b10, 0, 1);
        step(64'h8000_0028, 0, 0, 0, 0, 0, 1);
        chk("err_valid", {63'd0, inst_valid}, 64'd1);
        chk("err_fault", {63'd0, inst_fault}, 64'd1);
        step(64'h8000_0028, 0, 0, 0, 0, 0, 1);
        step(64'h8000_0028, 1, 0, 0, 0, 0, 1);
        step(64'h8000_0028, 0, 1, BEAT, 2'b00, 0, 1);
        step(64'h8000_0028, 0, 0, 0, 0, 0, 1);
        chk("ok_fault", {63'd0, inst_fault}, 64'd0);
        chk("ok_inst", {32'd0, inst}, 64'h0000_0413);

        // Asynchronous reset while waiting for read data.
        step(64'h8000_0200, 0, 0, 0, 0, 0, 1);
        step(64'h8000_0200, 1, 0, 0, 0, 0, 1);
        @(negedge clock);
        arready = 0; rvalid = 0; redirect = 0;
        #3 reset = 1'b0;
        #1;
        chk("arst_arvalid", {63'd0, arvalid}, 64'd0);
        chk("arst_rready", {63'd0, rready}, 64'd0);
        chk("arst_inst_valid", {63'd0, inst_valid}, 64'd0);
        model_reset();
        @(posedge clock);
        #2 reset = 1'b1;
        step(64'h8000_0300, 0, 0, 0, 0, 0, 1);
        step(64'h8000_0300, 1, 0, 0, 0, 0, 1);
        chk("arst_first_araddr", araddr, 64'h8000_0300);

        // Randomized traffic.
        for (int n = 0; n < 4000; n++) begin
            rpc = 64'h8000_0000 + 64'($urandom_range(0, 16383) * 4);
            rd  = {$urandom, $urandom};
            rr  = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            step(rpc, ($urandom_range(0, 2) != 0), ($urandom_range(0, 2) != 0), rd, rr,
                 ($urandom_range(0, 9) == 0), ($urandom_range(0, 1) != 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
